ten_gig_eth_pcs_pma_0_cdc_handshake_tx: RTL and testbench

//  Source-side (sending) end of a toggle-handshake clock-domain crossing for a multi-bit word.
//  - Captures a word from the local clk domain and holds it stable on xfer_data.
//  - Flips the xfer_req level, then waits for the far domain to return the same level on xfer_ack.
//  - xfer_ack is re-synchronized internally by a multi-stage ASYNC_REG flop chain.
//  - Sits beside the PCS/PMA FF synchronizers; the far end samples xfer_data once it sees req toggle.

---
 rtl/ten_gig_eth_pcs_pma_0_cdc_handshake_tx.sv | 153 +++++++++++++++
 tb/tb_ten_gig_eth_pcs_pma_0_cdc_handshake_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ten_gig_eth_pcs_pma_0_cdc_handshake_tx.sv
// ten_gig_eth_pcs_pma_0_cdc_handshake_tx
//
// Sending end of a toggle-handshake clock-domain crossing for a multi-bit word.
// A word accepted from the local domain is registered onto xfer_data. The xfer_req
// level is then flipped. The block waits until the far domain returns the same level
// on xfer_ack, which is resynchronized here through a flop chain.
//
// Optional feature macro: HS_TIMEOUT_EN
//   When defined, an acknowledge that does not come back within C_TIMEOUT_CYCLES
//   cycles aborts the wait and sets the sticky timeout_err. When undefined,
//   timeout_err is tied low and the block waits indefinitely.
//
// Ports
//   clk          local clock, rising edge
//   rst          asynchronous active-high reset
//   src_valid    word offered on src_data
//   src_data     word to transfer
//   src_ready    block can accept (transfer on src_valid & src_ready)
//   xfer_data    registered word to far domain, stable from toggle until ack
//   xfer_req     registered request toggle level to far domain
//   xfer_ack     ack toggle level from far domain (asynchronous to clk)
//   busy         high while not idle
//   done_pulse   one-cycle pulse when the far end acknowledged the word
//   timeout_err  sticky: ack not returned in time (HS_TIMEOUT_EN only)
module ten_gig_eth_pcs_pma_0_cdc_handshake_tx #(
  parameter int unsigned C_DATA_WIDTH     = 8,
  parameter int unsigned C_NUM_SYNC_REGS  = 3,
  parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_valid,
  input  logic [C_DATA_WIDTH-1:0] src_data,
  output logic                    src_ready,
  output logic [C_DATA_WIDTH-1:0] xfer_data,
  output logic                    xfer_req,
  input  logic                    xfer_ack,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StDone
  } state_e;

  state_e state_q;

  // Ack resynchronizer; only the last stage is used by the control logic.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [C_NUM_SYNC_REGS-1:0] ack_sync_q;
  logic                       ack_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[C_NUM_SYNC_REGS-2:0], xfer_ack};
    end
  end

  assign ack_sync = ack_sync_q[C_NUM_SYNC_REGS-1];

  // Levels must match before a new toggle, otherwise a stale ack (after reset or an
  // abort) would be mistaken for the answer to the next request.
  assign src_ready = (state_q == StIdle) && (ack_sync == xfer_req);
  assign busy      = (state_q != StIdle);

`ifdef HS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(C_TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      xfer_data   <= '0;
      xfer_req    <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state_q)
        StIdle: begin
          if (src_valid && src_ready) begin
            xfer_data <= src_data;
            xfer_req  <= ~xfer_req;
            cnt_q     <= '0;
            state_q   <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_sync == xfer_req) begin
            done_pulse <= 1'b1;
            state_q    <= StDone;
          end else if (cnt_q == CntLast) begin
            // xfer_req is left as is; src_ready stays low until the ack catches up.
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      xfer_data  <= '0;
      xfer_req   <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state_q)
        StIdle: begin
          if (src_valid && src_ready) begin
            xfer_data <= src_data;
            xfer_req  <= ~xfer_req;
            state_q   <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_sync == xfer_req) begin
            done_pulse <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ten_gig_eth_pcs_pma_0_cdc_handshake_tx.sv
module tb_ten_gig_eth_pcs_pma_0_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] xfer_data;
  logic       xfer_req;
  logic       xfer_ack;
  logic       busy;
  logic       done_pulse;
  logic       timeout_err;

  // Ack source: either a loopback of xfer_req or a bench-forced level.
  logic loopback;
  logic ack_force;
  assign xfer_ack = loopback ? xfer_req : ack_force;

  always #5 clk = ~clk;

  ten_gig_eth_pcs_pma_0_cdc_handshake_tx #(
    .C_DATA_WIDTH    (8),
    .C_NUM_SYNC_REGS (3),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .xfer_data  (xfer_data),
    .xfer_req   (xfer_req),
    .xfer_ack   (xfer_ack),
    .busy       (busy),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  bit         acc = 1'b0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: push accepted words, advance, then compare any acknowledged word.
  task automatic step();
    acc = 1'b0;
    if (src_valid === 1'b1 && src_ready === 1'b1) begin
      sb.push_back(src_data);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done_pulse === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        check("done_without_word", 32'(done_pulse), 32'd0);
      end else begin
        check("done_data", 32'(xfer_data), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_valid = 1'b0;
    src_data  = 8'h00;
    loopback  = 1'b1;
    ack_force = 1'b0;
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_req", 32'(xfer_req), 32'd0);
    check("rst_data", 32'(xfer_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd1);
  endtask

  initial begin
    int n;
    int d0;
    int first;

    // 1: single word, loopback latency
    do_reset();
    src_valid = 1'b1;
    src_data  = 8'hA5;
    step();
    src_valid = 1'b0;
    check("t1_xdata", 32'(xfer_data), 32'hA5);
    check("t1_req", 32'(xfer_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_wait", 32'(src_ready), 32'd0);
    n = 0;
    while (done_pulse !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("t1_latency", 32'(n), 32'd4);
    check("t1_ready_done", 32'(src_ready), 32'd0);
    step();
    check("t1_pulse_len", 32'(done_pulse), 32'd0);
    check("t1_ready_back", 32'(src_ready), 32'd1);
    check("t1_busy_back", 32'(busy), 32'd0);

    // 2: back-to-back words with src_valid held
    do_reset();
    d0        = done_cnt;
    src_valid = 1'b1;
    src_data  = 8'h01;
    step();
    check("t2_req1", 32'(xfer_req), 32'd1);
    src_data = 8'h02;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      step();
      n++;
    end
    first = done_cyc;
    check("t2_xdata1_held", 32'(xfer_data), 32'h01);
    n = 0;
    while (!acc && n < 20) begin
      step();
      n++;
    end
    src_valid = 1'b0;
    check("t2_accept_gap", 32'(cyc - first), 32'd2);
    check("t2_req0", 32'(xfer_req), 32'd0);
    check("t2_xdata2", 32'(xfer_data), 32'h02);
    n = 0;
    while (done_cnt == d0 + 1 && n < 20) begin
      step();
      n++;
    end
    check("t2_pulse_gap", 32'(done_cyc - first), 32'd6);
    check("t2_pulse_count", 32'(done_cnt - d0), 32'd2);

    // 3: src_data changes during WAIT_ACK
    do_reset();
    src_valid = 1'b1;
    src_data  = 8'h01;
    step();
    src_valid = 1'b0;
    src_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold", 32'(xfer_data), 32'h01);
    end
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: ack forced high through reset
    rst       = 1'b1;
    loopback  = 1'b0;
    ack_force = 1'b1;
    src_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t4_ready_mismatch", 32'(src_ready), 32'd0);
    d0        = done_cnt;
    src_valid = 1'b1;
    src_data  = 8'h77;
    step();
    check("t4_ignored_data", 32'(xfer_data), 32'd0);
    check("t4_ignored_req", 32'(xfer_req), 32'd0);
    check("t4_ignored_busy", 32'(busy), 32'd0);
    ack_force = 1'b0;
    step();
    step();
    check("t4_ready_edge2", 32'(src_ready), 32'd0);
    src_valid = 1'b0;
    step();
    check("t4_ready_edge3", 32'(src_ready), 32'd1);
    check("t4_data_still", 32'(xfer_data), 32'd0);
    // ack toggles while idle and matched
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t4_tog_ready", 32'(src_ready), 32'd0);
    check("t4_tog_busy", 32'(busy), 32'd0);
    check("t4_tog_terr", 32'(timeout_err), 32'd0);
    ack_force = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("t4_tog_ready_back", 32'(src_ready), 32'd1);
    check("t4_no_pulse", 32'(done_cnt - d0), 32'd0);

    // 5: reset mid-transfer
    do_reset();
    d0        = done_cnt;
    src_valid = 1'b1;
    src_data  = 8'h3C;
    step();
    src_valid = 1'b0;
    step();
    check("t5_busy_before", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_req", 32'(xfer_req), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_data", 32'(xfer_data), 32'd0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_no_pulse_rst", 32'(done_pulse), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t5_ready", 32'(src_ready), 32'd1);
    check("t5_no_pulse", 32'(done_cnt - d0), 32'd0);

    // 6: ack stuck low after accept
    do_reset();
    d0        = done_cnt;
    loopback  = 1'b0;
    ack_force = 1'b0;
    src_valid = 1'b1;
    src_data  = 8'h5A;
    step();
    src_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("t6_busy_15", 32'(busy), 32'd1);
    check("t6_terr_15", 32'(timeout_err), 32'd0);
    step();
`ifdef HS_TIMEOUT_EN
    check("t6_terr_16", 32'(timeout_err), 32'd1);
    check("t6_idle_16", 32'(busy), 32'd0);
    check("t6_ready_16", 32'(src_ready), 32'd0);
    sb.delete();
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t6_ready_catchup", 32'(src_ready), 32'd1);
    check("t6_terr_sticky", 32'(timeout_err), 32'd1);
`else
    for (int i = 0; i < 24; i++) step();
    check("t6_busy_forever", 32'(busy), 32'd1);
    check("t6_terr_tied", 32'(timeout_err), 32'd0);
    check("t6_req_held", 32'(xfer_req), 32'd1);
`endif
    check("t6_no_pulse", 32'(done_cnt - d0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
